// File: rtl/tof_mem_reader_if.sv
// ---------------------------------------------------------------------------
// tof_mem_reader_if
// Bundles the signals between the capture-memory reader and its neighbours:
//   all_data_written : level from the sample writer, rising edge starts a frame
//   enb / addrb      : BRAM port B read strobe and address
//   doutb            : BRAM port B read data
//   m_valid / m_data : byte stream towards the host-link transmitter
//   m_ready          : transmitter accepts a byte on m_valid & m_ready
//   busy / done      : frame-in-progress level and end-of-frame pulse
// master = the reader, slave = the environment (writer, BRAM, transmitter).
// ---------------------------------------------------------------------------
interface tof_mem_reader_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    logic                  all_data_written;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  m_valid;
    logic [7:0]            m_data;
    logic                  m_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  all_data_written, doutb, m_ready,
        output enb, addrb, m_valid, m_data, busy, done
    );

    modport slave (
        output all_data_written, doutb, m_ready,
        input  enb, addrb, m_valid, m_data, busy, done
    );
endinterface

// File: rtl/tof_mem_reader.sv
// ---------------------------------------------------------------------------
// tof_mem_reader
// Reads NUM_WORDS words from the capture BRAM (port B) starting at address 0
// once the writer reports all slots written, and streams them MSB byte first
// behind a HEADER byte over a valid/ready byte interface.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset, aborts any frame in progress
//   bus   : tof_mem_reader_if.master (BRAM port B, byte stream, busy/done)
// ---------------------------------------------------------------------------
module tof_mem_reader #(
    parameter int         ADDR_WIDTH = 9,
    parameter int         DATA_WIDTH = 16,
    parameter int         NUM_WORDS  = 511,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    tof_mem_reader_if.master  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = $clog2(BYTES + 1);
    localparam int WCW   = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_adw_q;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BCW-1:0]        r_bcnt;
    logic [WCW-1:0]        r_wcnt;

    logic                  w_start;
    logic                  w_last_word;
    logic                  w_last_byte;
    logic                  w_wait_done;
    logic                  w_enb;
    logic                  w_valid;
    logic [7:0]            w_data;

    // Only a fresh rising edge starts a frame; a held level never retriggers.
    assign w_start     = bus.all_data_written & ~r_adw_q;
    assign w_last_word = (r_addr == ADDR_WIDTH'(NUM_WORDS - 1));
    assign w_last_byte = (r_bcnt == BCW'(1));
    // WAIT spans RD_LATENCY cycles; doutb is valid in the last of them.
    assign w_wait_done = (r_wcnt == WCW'(RD_LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_enb   = 1'b0;
        w_valid = 1'b0;
        w_data  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_HEADER;
            end
            S_HEADER: begin
                w_valid = 1'b1;
                w_data  = HEADER;
                if (bus.m_ready) w_next = S_READ;
            end
            S_READ: begin
                w_enb  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_done) w_next = S_SEND;
            end
            S_SEND: begin
                w_valid = 1'b1;
                w_data  = r_shift[DATA_WIDTH-1 -: 8];
                if (bus.m_ready && w_last_byte)
                    w_next = w_last_word ? S_DONE : S_READ;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adw_q <= 1'b0;
            r_addr  <= '0;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_adw_q <= bus.all_data_written;
            case (r_state)
                S_READ: r_wcnt <= '0;
                S_WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_wait_done) begin
                        r_shift <= bus.doutb;
                        r_bcnt  <= BCW'(BYTES);
                    end
                end
                S_SEND: begin
                    if (bus.m_ready) begin
                        r_shift <= r_shift << 8;
                        r_bcnt  <= r_bcnt - 1'b1;
                        // Address stops at the last word, so no wrap in a frame.
                        if (w_last_byte && !w_last_word) r_addr <= r_addr + 1'b1;
                    end
                end
                S_DONE: r_addr <= '0;
                default: ;
            endcase
        end
    end

    assign bus.enb     = w_enb;
    assign bus.addrb   = r_addr;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_data;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
endmodule

// File: tb/tb_tof_mem_reader.sv
module tb_tof_mem_reader;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    tof_mem_reader_if #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) bus0 ();
    tof_mem_reader_if #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) bus1 ();

    tof_mem_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .NUM_WORDS(4),
                     .RD_LATENCY(1), .HEADER(8'hA5))
        dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    tof_mem_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .NUM_WORDS(4),
                     .RD_LATENCY(2), .HEADER(8'hA5))
        dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    // BRAM models
    logic [15:0] mem [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    logic [15:0] r1_stage;
    always @(posedge clk) if (bus0.enb) bus0.doutb <= mem[bus0.addrb[1:0]];
    always @(posedge clk) begin
        if (bus1.enb) r1_stage <= mem[bus1.addrb[1:0]];
        bus1.doutb <= r1_stage;
    end

    logic [7:0] exp_b [9] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Observation taps
    logic [1:0] vld, rdy_i, enb_s, done_s, busy_s;
    logic [7:0] dat [2];
    logic [8:0] adr [2];
    assign vld[0] = bus0.m_valid;   assign vld[1] = bus1.m_valid;
    assign rdy_i[0] = bus0.m_ready; assign rdy_i[1] = bus1.m_ready;
    assign enb_s[0] = bus0.enb;     assign enb_s[1] = bus1.enb;
    assign done_s[0] = bus0.done;   assign done_s[1] = bus1.done;
    assign busy_s[0] = bus0.busy;   assign busy_s[1] = bus1.busy;
    assign dat[0] = bus0.m_data;    assign dat[1] = bus1.m_data;
    assign adr[0] = bus0.addrb;     assign adr[1] = bus1.addrb;

    // Monitor: sampled mid-cycle; a handshake seen here completes at the next posedge.
    int         cyc = 0;
    logic [7:0] blog [2][256];
    int         bcnt [2] = '{0, 0};
    int         last_hs [2] = '{0, 0};
    int         stall_err [2] = '{0, 0};
    logic       stall_prev [2] = '{1'b0, 1'b0};
    logic [7:0] stall_dat [2];
    int         enb_cnt [2] = '{0, 0};
    int         busy_cyc [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         done_gap [2] = '{0, 0};
    logic       busy_at_done [2] = '{1'b0, 1'b0};
    logic       busy_after [2] = '{1'b1, 1'b1};
    logic       prev_done [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (vld[d] && rdy_i[d]) begin
                if (bcnt[d] < 256) blog[d][bcnt[d]] = dat[d];
                bcnt[d]++;
                last_hs[d] = cyc;
            end
            if (stall_prev[d] && (!vld[d] || dat[d] !== stall_dat[d])) stall_err[d]++;
            stall_prev[d] = vld[d] && !rdy_i[d];
            stall_dat[d]  = dat[d];
            if (enb_s[d])  enb_cnt[d]++;
            if (busy_s[d]) busy_cyc[d]++;
            if (prev_done[d]) busy_after[d] = busy_s[d];
            if (done_s[d]) begin
                done_cnt[d]++;
                done_gap[d]     = cyc - last_hs[d];
                busy_at_done[d] = busy_s[d];
            end
            prev_done[d] = done_s[d];
        end
        cyc++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rdy(input int d, input logic v);
        if (d == 0) bus0.m_ready = v; else bus1.m_ready = v;
    endtask

    task automatic set_adw(input int d, input logic v);
        if (d == 0) bus0.all_data_written = v; else bus1.all_data_written = v;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic run_frame(input int d, input int mode, input string tag);
        logic got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (mode == 0) set_rdy(d, 1'b1);
            else           set_rdy(d, ((k % 4) == 0) || ((k % 4) == 3));
            tick();
            if (done_s[d]) begin got = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        set_rdy(d, 1'b1);
        tick(); tick();
    endtask

    task automatic check_frame(input int d, input int base, input string tag);
        chk({tag, "_len"}, 32'(bcnt[d] - base), 32'd9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(blog[d][(base + i) % 256]), 32'(exp_b[i]));
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, "_enb"},   32'(enb_s[d]),  32'd0);
        chk({tag, "_addrb"}, 32'(adr[d]),    32'd0);
        chk({tag, "_valid"}, 32'(vld[d]),    32'd0);
        chk({tag, "_data"},  32'(dat[d]),    32'd0);
        chk({tag, "_busy"},  32'(busy_s[d]), 32'd0);
        chk({tag, "_done"},  32'(done_s[d]), 32'd0);
    endtask

    initial begin
        int b, dc, ec, bc;
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.all_data_written = 1'b0; bus1.all_data_written = 1'b0;
        bus0.m_ready = 1'b1; bus1.m_ready = 1'b1;
        tick(); tick();
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        // Basic frame, latency 1
        b = bcnt[0]; dc = done_cnt[0]; ec = enb_cnt[0]; bc = busy_cyc[0];
        set_adw(0, 1'b1);
        tick();
        chk("basic_hdr_valid", 32'(vld[0]), 32'd1);
        chk("basic_hdr_data",  32'(dat[0]), 32'hA5);
        chk("basic_hdr_busy",  32'(busy_s[0]), 32'd1);
        set_adw(0, 1'b0);
        run_frame(0, 0, "basic");
        check_frame(0, b, "basic");
        chk("basic_done_cnt",  32'(done_cnt[0] - dc), 32'd1);
        chk("basic_done_gap",  32'(done_gap[0]), 32'd1);
        chk("basic_busy_done", 32'(busy_at_done[0]), 32'd1);
        chk("basic_busy_fall", 32'(busy_after[0]), 32'd0);
        chk("basic_busy_cyc",  32'(busy_cyc[0] - bc), 32'd18);
        chk("basic_enb_cnt",   32'(enb_cnt[0] - ec), 32'd4);
        chk("basic_addr_clr",  32'(adr[0]), 32'd0);

        // Back-pressure
        b = bcnt[0]; ec = enb_cnt[0];
        set_adw(0, 1'b1); tick(); set_adw(0, 1'b0);
        run_frame(0, 1, "bp");
        check_frame(0, b, "bp");
        chk("bp_stall_err", 32'(stall_err[0]), 32'd0);
        chk("bp_enb_cnt",   32'(enb_cnt[0] - ec), 32'd4);

        // Read latency 2
        b = bcnt[1]; bc = busy_cyc[1]; dc = done_cnt[1];
        set_adw(1, 1'b1); tick(); set_adw(1, 1'b0);
        run_frame(1, 0, "lat2");
        check_frame(1, b, "lat2");
        chk("lat2_busy_cyc", 32'(busy_cyc[1] - bc), 32'd22);
        chk("lat2_done_cnt", 32'(done_cnt[1] - dc), 32'd1);

        // Level retrigger: held high yields one frame only
        b = bcnt[0]; dc = done_cnt[0];
        set_adw(0, 1'b1);
        run_frame(0, 0, "lvl1");
        repeat (100) tick();
        check_frame(0, b, "lvl1");
        chk("lvl1_done_cnt", 32'(done_cnt[0] - dc), 32'd1);
        chk("lvl1_idle",     32'(busy_s[0]), 32'd0);
        set_adw(0, 1'b0); tick(); set_adw(0, 1'b1);
        b = bcnt[0];
        run_frame(0, 0, "lvl2");
        check_frame(0, b, "lvl2");
        set_adw(0, 1'b0);
        tick();

        // Reset after the 3rd data byte, input held high so the frame restarts
        b = bcnt[0]; dc = done_cnt[0];
        set_adw(0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bcnt[0] - b >= 4) break;
        end
        chk("rst_mid_bytes", 32'(bcnt[0] - b), 32'd4);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk_reset(0, "rst_mid");
        b = bcnt[0];
        run_frame(0, 0, "rst_re");
        check_frame(0, b, "rst_re");
        chk("rst_done_cnt", 32'(done_cnt[0] - dc), 32'd1);
        set_adw(0, 1'b0);
        tick();

        // Ignored start edge while busy
        b = bcnt[1]; dc = done_cnt[1];
        set_adw(1, 1'b1); tick(); set_adw(1, 1'b0);
        repeat (5) tick();
        chk("ign_busy", 32'(busy_s[1]), 32'd1);
        set_adw(1, 1'b1); tick(); set_adw(1, 1'b0);
        run_frame(1, 0, "ign");
        repeat (10) tick();
        check_frame(1, b, "ign");
        chk("ign_done_cnt", 32'(done_cnt[1] - dc), 32'd1);
        chk("ign_idle",     32'(busy_s[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tof_mem_reader.md
# tof_mem_reader

Downstream stage of the ToF sample-capture memory writer. Once the writer reports all sample slots written, this block reads the capture BRAM port B sequentially from address 0 and serialises each word into a byte stream. The stream is framed with a header byte and handed over a valid/ready interface to the host-link transmitter (UART TX path). It raises a one-cycle done pulse when the last byte has been accepted.

## Interface
Parameters:
- ADDR_WIDTH, 9, BRAM port B address width
- DATA_WIDTH, 16, BRAM word width; must be a multiple of 8
- NUM_WORDS, 511, words read per frame (matches writer's 0x1FF slot count); range 1 to 2^ADDR_WIDTH
- RD_LATENCY, 1, BRAM read latency in cycles from enb to valid doutb; legal values 1 or 2
- HEADER, 8'hA5, frame start byte

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- all_data_written, in, 1, level from writer; rising edge starts a frame
- enb, out, 1, BRAM port B enable (read strobe)
- addrb, out, ADDR_WIDTH, BRAM port B address
- doutb, in, DATA_WIDTH, BRAM port B read data
- m_valid, out, 1, byte available
- m_data, out, 8, byte value
- m_ready, in, 1, sink accepts byte when m_valid & m_ready
- busy, out, 1, frame in progress
- done, out, 1, one-cycle pulse after last byte accepted

## Operation
- Start detect: registered copy of all_data_written; start = input high & registered copy low. Start is ignored unless the state is IDLE. A level held high does not retrigger; the input must drop low first.
- States and transitions:
  - IDLE → HEADER on start.
  - HEADER: m_valid=1, m_data=HEADER. Moves to READ on handshake.
  - READ: enb=1 for exactly one cycle at addrb, then moves to WAIT.
  - WAIT: counts RD_LATENCY cycles, then loads doutb into the shift register. Byte counter is set to DATA_WIDTH/8; moves to SEND.
  - SEND: m_valid=1, m_data = shift register MSB byte. Each handshake shifts left 8 and decrements the byte counter.
  - On the handshake of the last byte: if addrb == NUM_WORDS-1, go to DONE. Otherwise increment addrb and go to READ.
  - DONE: done=1 for one cycle, addrb cleared to 0, then go to IDLE.
- Byte order per word: most-significant byte first.
- Frame length is 1 + NUM_WORDS·DATA_WIDTH/8 bytes.
- busy = 1 in every state except IDLE.
- Stream rules:
  - m_data and m_valid hold stable while m_valid & !m_ready.
  - m_valid is never deasserted without a handshake.
  - m_valid is 0 in IDLE, READ, WAIT and DONE.
- Address arithmetic: addrb is ADDR_WIDTH unsigned and never exceeds NUM_WORDS-1, so there is no wrap within a frame.
- Reset mid-frame: abort immediately and return to IDLE with all outputs at reset values. No done pulse. The start-edge register is also reset, so an all_data_written input still high after reset counts as a new rising edge.

## Timing
- Reset values: enb=0, addrb=0, m_valid=0, m_data=8'h00, busy=0, done=0.
- Start to header: HEADER with m_valid=1 in the cycle after the start edge is sampled.
- Per word with m_ready held high: 1 (READ) + RD_LATENCY (WAIT) + DATA_WIDTH/8 (SEND) cycles. With defaults that is 4 cycles.
- Full frame with defaults and m_ready high: 1 + 511·4 + 1 (DONE) = 2046 cycles after leaving IDLE.
- done asserts in the cycle after the last byte's handshake.
- busy falls in the same cycle that done falls.
- Back-pressure: m_ready low stalls SEND or HEADER indefinitely; enb is not reasserted during a stall.

## Test plan
- Basic frame: NUM_WORDS=4; BRAM model (RD_LATENCY=1) holds 16'h1122, 16'h3344, 16'h5566, 16'h7788; m_ready=1; pulse all_data_written high.
  - Required bytes: A5,11,22,33,44,55,66,77,88.
  - done pulses once, 1 cycle after byte 88 is accepted; busy is high from the start edge through the DONE cycle.
- Back-pressure: same setup with m_ready toggling 1,0,0,1 repeating.
  - Identical byte sequence.
  - m_data is unchanged across every stalled cycle; enb pulses exactly 4 times.
- RD_LATENCY=2: same data as the basic frame.
  - Same bytes.
  - The WAIT state lasts 2 cycles per word; total frame is 1+4·5+1 = 22 cycles with m_ready=1.
- Level retrigger: hold all_data_written high for 100 cycles after the frame ends.
  - Exactly one frame is sent.
  - Drop low for 1 cycle, then raise again: a second identical frame follows.
- Reset mid-frame: assert reset for 1 cycle after the 3rd data byte.
  - All outputs return to reset values the next cycle; no done pulse.
  - A new start edge produces a complete frame from address 0.
- Ignored start: toggle all_data_written low then high while busy.
  - The frame is not restarted and byte order is unaffected.
  - The new edge is not remembered after DONE.
